// File: rtl/i2s_tx_pkg.sv
// Shared constants and helpers for the I2S transmitter.
// Channel masks, slot geometry and sample-size decoding.
package i2s_tx_pkg;

  localparam int SLOT_BITS = 32;

  localparam logic [1:0] CH_NONE   = 2'b00;
  localparam logic [1:0] CH_RIGHT  = 2'b01;
  localparam logic [1:0] CH_LEFT   = 2'b10;
  localparam logic [1:0] CH_STEREO = 2'b11;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // A programmed size of 0 means a full 32-bit sample.
  function automatic logic [5:0] eff_size(input logic [5:0] size);
    return (size == 6'd0) ? 6'd32 : size;
  endfunction

  function automatic logic chan_enabled(input logic [1:0] channels, input slot_e slot);
    return (slot == SLOT_LEFT) ? channels[1] : channels[0];
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the I2S serialiser.
// Pushes while full and pops while empty are ignored.
module i2s_tx_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;

  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: sck/ws generation and MSB-first serialisation
// of FIFO samples in Philips or left-justified format.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ws,
  output logic          sck,
  output logic          sdo,
  input  logic          fifo_wr,
  input  logic [DW-1:0] fifo_wdata,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_level,
  input  logic [AW:0]   fifo_level_threshold,
  output logic          fifo_level_below,
  output logic          underflow,
  input  logic          underflow_clr,
  input  logic          left_justified,
  input  logic [5:0]    sample_size,
  input  logic [7:0]    sck_prescaler,
  input  logic [1:0]    channels,
  input  logic          en
);

  logic [7:0]    prescaler;
  logic [4:0]    bit_ctr;
  logic [31:0]   shifter;
  logic [31:0]   shifter_next;
  logic [31:0]   loaded;
  logic [5:0]    shamt;
  logic [DW-1:0] head;
  logic          sdo_dly;
  logic          lj_q;
  logic          lj_eff;
  logic          cur_bit;
  logic          tick;
  logic          fall;
  logic          slot_start;
  logic          ch_en;
  logic          pop;
  slot_e         next_slot;

  i2s_tx_fifo #(.AW(AW), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_level_below = (fifo_level < fifo_level_threshold);

  assign tick       = en && (prescaler == 8'd0);
  assign fall       = tick && sck;
  assign slot_start = fall && (bit_ctr == 5'd31);

  // ws is about to toggle, so the new slot is left when ws is currently 1.
  assign next_slot = ws ? SLOT_LEFT : SLOT_RIGHT;
  assign ch_en     = chan_enabled(channels, next_slot);
  assign pop       = slot_start && ch_en && !fifo_empty;

  // Shifting left by (32-N) both MSB-aligns the sample and discards bits above N-1.
  assign shamt  = 6'(SLOT_BITS) - eff_size(sample_size);
  assign loaded = head << shamt;

  always_comb begin
    shifter_next = {shifter[30:0], 1'b0};
    if (slot_start) shifter_next = pop ? loaded : '0;
  end

  assign cur_bit = shifter_next[31];
  assign lj_eff  = slot_start ? left_justified : lj_q;

  // All frame state advances on the sck falling-edge tick and freezes while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      sck       <= 1'b0;
      ws        <= 1'b1;
      bit_ctr   <= '0;
      shifter   <= '0;
      sdo       <= 1'b0;
      sdo_dly   <= 1'b0;
      lj_q      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (en) prescaler <= (prescaler == 8'd0) ? sck_prescaler : prescaler - 8'd1;
      if (tick) sck <= ~sck;
      if (fall) begin
        bit_ctr <= bit_ctr + 5'd1;
        shifter <= shifter_next;
        sdo_dly <= cur_bit;
        sdo     <= lj_eff ? cur_bit : sdo_dly;
        if (slot_start) begin
          ws   <= ~ws;
          lj_q <= left_justified;
        end
      end
      if (slot_start && ch_en && fifo_empty) underflow <= 1'b1;
      else if (underflow_clr)                underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised self-checking bench for i2s_tx against a frame-level model
// that derives sck/ws/sdo from elapsed clock counts and slot contents.
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic        ws;
  logic        sck;
  logic        sdo;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic [4:0]  fifo_level_threshold;
  logic        fifo_level_below;
  logic        underflow;
  logic        underflow_clr;
  logic        left_justified;
  logic [5:0]  sample_size;
  logic [7:0]  sck_prescaler;
  logic [1:0]  channels;
  logic        en;

  int checks = 0;
  int errors = 0;

  logic [31:0] stim_q[$];
  logic [31:0] words[64];
  int          uf_slot;

  i2s_tx #(.AW(4), .DW(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ws                   (ws),
    .sck                  (sck),
    .sdo                  (sdo),
    .fifo_wr              (fifo_wr),
    .fifo_wdata           (fifo_wdata),
    .fifo_full            (fifo_full),
    .fifo_empty           (fifo_empty),
    .fifo_level           (fifo_level),
    .fifo_level_threshold (fifo_level_threshold),
    .fifo_level_below     (fifo_level_below),
    .underflow            (underflow),
    .underflow_clr        (underflow_clr),
    .left_justified       (left_justified),
    .sample_size          (sample_size),
    .sck_prescaler        (sck_prescaler),
    .channels             (channels),
    .en                   (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit carried by falling edge k in left-justified form; slot 0 is the dummy slot.
  function automatic logic lj_bit(input int k);
    logic [31:0] w;
    if (k < 32) return 1'b0;
    w = words[k / 32];
    return w[31 - (k % 32)];
  endfunction

  task automatic do_reset_dut();
    rst_n = 1'b0;
    en = 1'b0;
    fifo_wr = 1'b0;
    underflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_sample(input logic [31:0] d);
    fifo_wr = 1'b1;
    fifo_wdata = d;
    @(posedge clk);
    #1 fifo_wr = 1'b0;
  endtask

  // Pushes stim_q with en=0, then runs nslots slots past the dummy slot checking every tick.
  task automatic run_stream(input int p, input logic lj, input logic [5:0] size,
                            input logic [1:0] ch, input int nslots, input logic do_reset);
    logic [31:0] q[$];
    logic [31:0] s;
    longint unsigned v;
    int n_eff, stored, pops, kmax, t, last_t, last_k, k, thr;
    logic exp_sdo, exp_ws, exp_uf;
    if (do_reset) do_reset_dut();
    en = 1'b0;
    left_justified = lj;
    sample_size = size;
    sck_prescaler = 8'(p);
    channels = ch;
    @(posedge clk);
    #1;
    foreach (stim_q[i]) push_sample(stim_q[i]);
    stored = (stim_q.size() > 16) ? 16 : stim_q.size();
    checks++;
    if (fifo_level !== 5'(stored) || fifo_full !== (stored == 16)) begin
      errors++;
      $display("[TB] FAIL fill_level: got level=%0d full=%0b expected level=%0d full=%0b",
               fifo_level, fifo_full, stored, stored == 16);
    end
    thr = $urandom_range(0, 17);
    fifo_level_threshold = 5'(thr);
    #1;
    checks++;
    if (fifo_level_below !== (stored < thr)) begin
      errors++;
      $display("[TB] FAIL level_below thr=%0d: got %0b expected %0b", thr, fifo_level_below, stored < thr);
    end

    for (int i = 0; i < stored; i++) q.push_back(stim_q[i]);
    n_eff = (size == 6'd0) ? 32 : int'(size);
    uf_slot = 1000;
    pops = 0;
    for (int j = 1; j <= nslots; j++) begin
      words[j] = 32'd0;
      if ((j % 2 == 1) ? ch[1] : ch[0]) begin
        if (q.size() > 0) begin
          s = q.pop_front();
          pops++;
          v = (longint'(s) % (64'd1 << n_eff)) * (64'd1 << (32 - n_eff));
          words[j] = v[31:0];
        end else if (uf_slot == 1000) begin
          uf_slot = j;
        end
      end
    end

    kmax = 32 * (nslots + 1) - 1;
    last_t = 0;
    last_k = 0;
    #1 en = 1'b1;
    for (int c = 1; c <= 2 * (p + 1) * kmax + 8 && last_k < kmax; c++) begin
      @(posedge clk);
      #1;
      t = (c + p) / (p + 1);
      if (t != last_t) begin
        last_t = t;
        checks++;
        if (sck !== t[0]) begin
          errors++;
          $display("[TB] FAIL sck tick=%0d: got %0b expected %0b", t, sck, t[0]);
        end
        k = t / 2;
        if (k != last_k) begin
          last_k = k;
          exp_sdo = lj ? lj_bit(k) : lj_bit(k - 1);
          exp_ws  = (k < 32) ? 1'b1 : ((k / 32) % 2 == 0);
          exp_uf  = ((k / 32) >= uf_slot);
          checks++;
          if (sdo !== exp_sdo) begin
            errors++;
            $display("[TB] FAIL sdo fall=%0d: got %0b expected %0b", k, sdo, exp_sdo);
          end
          checks++;
          if (ws !== exp_ws) begin
            errors++;
            $display("[TB] FAIL ws fall=%0d: got %0b expected %0b", k, ws, exp_ws);
          end
          checks++;
          if (underflow !== exp_uf) begin
            errors++;
            $display("[TB] FAIL underflow fall=%0d: got %0b expected %0b", k, underflow, exp_uf);
          end
        end
      end
    end
    en = 1'b0;
    checks++;
    if (last_k < kmax) begin
      errors++;
      $display("[TB] FAIL stream_timeout: got fall=%0d expected fall=%0d", last_k, kmax);
    end
    checks++;
    if (fifo_level !== 5'(stored - pops)) begin
      errors++;
      $display("[TB] FAIL end_level: got %0d expected %0d", fifo_level, stored - pops);
    end
  endtask

  task automatic test_reset();
    do_reset_dut();
    fifo_level_threshold = 5'd1;
    #1;
    checks++;
    if ({sck, ws, sdo, underflow} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL reset_pins: got sck/ws/sdo/uf=%b expected 0100", {sck, ws, sdo, underflow});
    end
    checks++;
    if (fifo_level !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_level_below !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_fifo: got level=%0d empty=%0b full=%0b below=%0b expected 0 1 0 1",
               fifo_level, fifo_empty, fifo_full, fifo_level_below);
    end
  endtask

  task automatic test_left_justified();
    stim_q = '{32'h0000A5C3, 32'h00001234};
    run_stream(1, 1'b1, 6'd16, 2'b11, 2, 1'b1);
  endtask

  task automatic test_philips();
    stim_q = '{32'h0000A5C3, 32'h00001234};
    run_stream(1, 1'b0, 6'd16, 2'b11, 2, 1'b1);
  endtask

  task automatic test_left_only_underflow();
    stim_q = '{32'h11, 32'h22};
    run_stream(0, 1'b1, 6'd8, 2'b10, 6, 1'b1);
    underflow_clr = 1'b1;
    @(posedge clk);
    #1 underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_clr: got %0b expected 0", underflow);
    end
  endtask

  task automatic test_fifo_overflow();
    stim_q = {};
    for (int i = 0; i < 17; i++) stim_q.push_back(32'(i));
    run_stream(0, 1'b1, 6'd8, 2'b11, 16, 1'b1);
  endtask

  task automatic test_sample_size();
    stim_q = '{32'hDEADBEEF};
    run_stream(0, 1'b1, 6'd0, 2'b10, 1, 1'b1);
    stim_q = '{32'hFFFFFFF5};
    run_stream(0, 1'b1, 6'd4, 2'b10, 1, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      stim_q = {};
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) stim_q.push_back($urandom);
      run_stream($urandom_range(0, 2), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 32)),
                 2'($urandom_range(0, 3)), $urandom_range(2, 5), 1'b1);
    end
  endtask

  task automatic test_reset_midslot();
    do_reset_dut();
    left_justified = 1'b1;
    sample_size = 6'd16;
    sck_prescaler = 8'd0;
    channels = 2'b11;
    for (int i = 0; i < 3; i++) push_sample($urandom);
    en = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_underflow: got %0b expected 1", underflow);
    end
    for (int i = 0; i < 3; i++) push_sample($urandom);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sck, ws, sdo, underflow} !== 4'b0100 || fifo_level !== 5'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got sck/ws/sdo/uf=%b level=%0d expected 0100 level=0",
               {sck, ws, sdo, underflow}, fifo_level);
    end
    en = 1'b0;
    #3 rst_n = 1'b1;
    stim_q = '{32'h0000BEEF, 32'h0000CAFE, 32'h00001357};
    run_stream(0, 1'b1, 6'd16, 2'b11, 3, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    fifo_wr = 1'b0;
    fifo_wdata = '0;
    fifo_level_threshold = '0;
    underflow_clr = 1'b0;
    left_justified = 1'b1;
    sample_size = 6'd16;
    sck_prescaler = 8'd0;
    channels = 2'b11;
    test_reset();
    test_left_justified();
    test_philips();
    test_left_only_underflow();
    test_fifo_overflow();
    test_sample_size();
    test_random();
    test_reset_midslot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
